// File: rtl/sisa_pkg.sv
// Shared types and instruction-field positions for the multi-cycle sISA core.
package sisa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LI  = 2'b10,
        OP_BNE = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Instruction layout: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2, [3:0] imm
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam int NUM_REGS = 4;

endpackage

// File: rtl/sisa_alu_flags.sv
// Combinational ADD/SUB unit producing the result plus zero and carry/borrow flags.
module sisa_alu_flags #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // The extra top bit of an unsigned subtraction is exactly the borrow (a < b).
    assign wide   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];
    assign zero   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/sisa_core_mc.sv
// Multi-cycle sISA core: FETCH/EXEC/HALT FSM fetching over a valid/ready port.
// Define SISA_INSTRET_EN to add the saturating 32-bit retired-instruction counter output.
module sisa_core_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [7:0]          imem_rdata,
    output logic                halted,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic [PC_W-1:0]     pc_debug,
    output logic [4*DATA_W-1:0] reg_debug
`ifdef SISA_INSTRET_EN
    ,
    output logic [31:0]         instret
`endif
);
    import sisa_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   target;
    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    opcode_t           opcode;
    logic [1:0]        rd;
    logic [1:0]        rs1;
    logic [1:0]        rs2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              fetch_fire;
    logic              branch_taken;

    assign opcode       = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd           = ir[RD_MSB:RD_LSB];
    assign rs1          = ir[RS1_MSB:RS1_LSB];
    assign rs2          = ir[RS2_MSB:RS2_LSB];
    assign target       = PC_W'(ir[IMM_MSB:IMM_LSB]);
    assign branch_taken = (opcode == OP_BNE) && (regs[rd] != regs[0]);

    // Reset suppresses the request so a response arriving during reset is never accepted.
    assign imem_req   = (state == ST_FETCH) && run && !reset;
    assign imem_addr  = pc;
    assign fetch_fire = imem_req && imem_ready;

    assign halted    = (state == ST_HALT);
    assign pc_debug  = pc;
    assign reg_debug = {regs[3], regs[2], regs[1], regs[0]};

    sisa_alu_flags #(.DATA_W(DATA_W)) u_alu (
        .a      (regs[rs1]),
        .b      (regs[rs2]),
        .sub    (opcode == OP_SUB),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A taken branch back onto itself is the halt idiom; PC stays on the branch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_FETCH: begin
                if (fetch_fire) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (branch_taken && (target == pc)) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                    pc_next    = branch_taken ? target : pc + PC_W'(1);
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (fetch_fire) begin
                ir <= imem_rdata;
            end
            if (state == ST_EXEC) begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        regs[rd]   <= alu_result;
                        zero_flag  <= alu_zero;
                        carry_flag <= alu_carry;
                    end
                    OP_LI: begin
                        regs[rd] <= DATA_W'(ir[IMM_MSB:IMM_LSB]);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SISA_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if ((state == ST_EXEC) && (instret != '1)) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule
